// File: rtl/mac_wide_mult_sequencer.sv
// Drives one 54x36 SIMD multiplier: four accumulated passes for a 108x72 wide
// product, or a single forwarded pass for the SIMD modes.
module mac_wide_mult_sequencer #(
    parameter int unsigned MUL_LATENCY = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op_mode,
    input  logic [107:0] a,
    input  logic [107:0] b,
    input  logic         a_sign,
    input  logic         b_sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [179:0] product,
    output logic [15:0]  sidm_carry,
    output logic [107:0] mul_a,
    output logic [107:0] mul_b,
    output logic         mul_a_sign,
    output logic         mul_b_sign,
    output logic [1:0]   mul_mode,
    input  logic [89:0]  mul_result_0,
    input  logic [89:0]  mul_result_1,
    input  logic [15:0]  mul_carry
);

    localparam int unsigned PW = 180;
    localparam int unsigned RW = 90;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [1:0]     pass;
    logic [1:0]     wait_cnt;
    logic [107:0]   a_q;
    logic [107:0]   b_q;
    logic           a_sign_q;
    logic           b_sign_q;
    logic [1:0]     mode_q;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  term_ext;
    logic [PW-1:0]  acc_sum;

    assign in_ready = (state == IDLE) && !reset;

    // Pass p selects the A half with p[0] and the B half with p[1]
    function automatic logic [107:0] wide_a(input logic [1:0] p, input logic [107:0] av);
        return {54'b0, p[0] ? av[107:54] : av[53:0]};
    endfunction

    function automatic logic [107:0] wide_b(input logic [1:0] p, input logic [71:0] bv);
        return {72'b0, p[1] ? bv[71:36] : bv[35:0]};
    endfunction

    // Partial product extended and weighted by its pass position
    always_comb begin
        term_ext = {{(PW-RW){(mul_a_sign | mul_b_sign) & mul_result_0[RW-1]}}, mul_result_0};
        acc_sum  = acc;
        case (pass)
            2'd0:    acc_sum = acc + term_ext;
            2'd1:    acc_sum = acc + (term_ext << 54);
            2'd2:    acc_sum = acc + (term_ext << 36);
            default: acc_sum = acc + (term_ext << 90);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pass       <= 2'd0;
            wait_cnt   <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            mode_q     <= 2'b00;
            acc        <= '0;
            product    <= '0;
            sidm_carry <= '0;
            out_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_a_sign <= 1'b0;
            mul_b_sign <= 1'b0;
            mul_mode   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        a_sign_q <= a_sign;
                        b_sign_q <= b_sign;
                        mode_q   <= op_mode;
                        acc      <= '0;
                        pass     <= 2'd0;
                        wait_cnt <= 2'(MUL_LATENCY);
                        state    <= RUN;
                        if (op_mode == 2'b00) begin
                            mul_a      <= wide_a(2'd0, a);
                            mul_b      <= wide_b(2'd0, b[71:0]);
                            mul_a_sign <= 1'b0;
                            mul_b_sign <= 1'b0;
                            mul_mode   <= 2'b00;
                        end else begin
                            mul_a      <= a;
                            mul_b      <= b;
                            mul_a_sign <= a_sign;
                            mul_b_sign <= b_sign;
                            mul_mode   <= op_mode;
                        end
                    end
                end
                RUN: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else if (mode_q != 2'b00 || pass == 2'd3) begin
                        if (mode_q != 2'b00) begin
                            product    <= {mul_result_1, mul_result_0};
                            sidm_carry <= mul_carry;
                        end else begin
                            product    <= acc_sum;
                            sidm_carry <= '0;
                        end
                        out_valid  <= 1'b1;
                        state      <= DONE;
                        mul_a      <= '0;
                        mul_b      <= '0;
                        mul_a_sign <= 1'b0;
                        mul_b_sign <= 1'b0;
                        mul_mode   <= 2'b00;
                    end else begin
                        acc        <= acc_sum;
                        pass       <= pass + 2'd1;
                        wait_cnt   <= 2'(MUL_LATENCY);
                        mul_a      <= wide_a(pass + 2'd1, a_q);
                        mul_b      <= wide_b(pass + 2'd1, b_q[71:0]);
                        mul_a_sign <= (pass[0] == 1'b0) & a_sign_q;
                        mul_b_sign <= (pass == 2'd1 || pass == 2'd2) & b_sign_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_wide_mult_sequencer.sv
// Directed bench for mac_wide_mult_sequencer with a behavioural 54x36 multiplier
// model; one instance at MUL_LATENCY=0 and one at MUL_LATENCY=2.
module tb_mac_wide_mult_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_valid2;
    logic [1:0]   op_mode;
    logic [107:0] a, b;
    logic         a_sign, b_sign;
    logic         out_ready, out_ready2;

    logic         in_ready0, out_valid0, mas0, mbs0;
    logic [179:0] product0;
    logic [15:0]  carry0, mc0;
    logic [107:0] ma0, mb0;
    logic [1:0]   mm0;
    logic [89:0]  r00, r10;

    logic         in_ready2, out_valid2, mas2, mbs2;
    logic [179:0] product2;
    logic [15:0]  carry2, mc2;
    logic [107:0] ma2, mb2;
    logic [1:0]   mm2;
    logic [89:0]  r02, r12;

    logic [89:0]  simd_r0, simd_r1;
    logic [15:0]  simd_c;

    int n_checks = 0;
    int n_fails  = 0;
    int n;

    always #5 clk = ~clk;

    mac_wide_mult_sequencer #(.MUL_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .op_mode(op_mode), .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign),
        .out_valid(out_valid0), .out_ready(out_ready), .product(product0),
        .sidm_carry(carry0), .mul_a(ma0), .mul_b(mb0), .mul_a_sign(mas0),
        .mul_b_sign(mbs0), .mul_mode(mm0), .mul_result_0(r00),
        .mul_result_1(r10), .mul_carry(mc0)
    );

    mac_wide_mult_sequencer #(.MUL_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_mode(op_mode), .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign),
        .out_valid(out_valid2), .out_ready(out_ready2), .product(product2),
        .sidm_carry(carry2), .mul_a(ma2), .mul_b(mb2), .mul_a_sign(mas2),
        .mul_b_sign(mbs2), .mul_mode(mm2), .mul_result_0(r02),
        .mul_result_1(r12), .mul_carry(mc2)
    );

    // 54x36 multiply with optional two's-complement operands, 90-bit result
    function automatic logic [89:0] mul_model(input logic [107:0] ma, input logic [107:0] mb,
                                              input logic sa, input logic sb);
        logic [89:0] pa, pb;
        pa = sa ? {{36{ma[53]}}, ma[53:0]} : {36'b0, ma[53:0]};
        pb = sb ? {{54{mb[35]}}, mb[35:0]} : {54'b0, mb[35:0]};
        return pa * pb;
    endfunction

    always_comb begin
        if (mm0 == 2'b00) begin
            r00 = mul_model(ma0, mb0, mas0, mbs0); r10 = '0; mc0 = '0;
        end else begin
            r00 = simd_r0; r10 = simd_r1; mc0 = simd_c;
        end
        if (mm2 == 2'b00) begin
            r02 = mul_model(ma2, mb2, mas2, mbs2); r12 = '0; mc2 = '0;
        end else begin
            r02 = simd_r0; r12 = simd_r1; mc2 = simd_c;
        end
    end

    task automatic check(input string tag, input logic [179:0] obs, input logic [179:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request to dut0, measure latency, check results, then handshake
    task automatic do_op(input string tag, input logic [1:0] m, input logic [107:0] av,
                         input logic [107:0] bv, input logic sa, input logic sb,
                         input int exp_lat, input logic [179:0] exp_p, input logic [15:0] exp_c);
        int k;
        @(negedge clk);
        check({tag, "_in_ready"}, 180'(in_ready0), 180'd1);
        in_valid = 1'b1; op_mode = m; a = av; b = bv; a_sign = sa; b_sign = sb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_mul_mode"}, 180'(mm0), 180'(m));
        if (m == 2'b00) begin
            check({tag, "_mul_a_hi"}, 180'(ma0[107:54]), 180'd0);
            check({tag, "_mul_b_hi"}, 180'(mb0[107:36]), 180'd0);
        end
        k = 0;
        while (!out_valid0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 180'(k), 180'(exp_lat));
        check({tag, "_product"}, product0, exp_p);
        check({tag, "_carry"}, 180'(carry0), 180'(exp_c));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 180'(out_valid0), 180'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
        op_mode = 2'b00; a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0;
        simd_r0 = '0; simd_r1 = '0; simd_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 180'(out_valid0), 180'd0);
        check("rst_product", product0, 180'd0);
        check("rst_in_ready", 180'(in_ready0), 180'd0);
        check("rst_mul_mode", 180'(mm0), 180'd0);
        reset = 1'b0;
        #1;
        check("rst_release_in_ready", 180'(in_ready0), 180'd1);

        do_op("wide_unsigned", 2'b00, 108'd3, 108'd5, 1'b0, 1'b0, 4, 180'd15, 16'd0);
        do_op("wide_signed", 2'b00, ~108'd0, 108'd2, 1'b1, 1'b0, 4, ~180'd1, 16'd0);
        do_op("wide_cross", 2'b00, 108'd1 << 60, 108'd1 << 40, 1'b0, 1'b0, 4, 180'd1 << 100, 16'd0);
        do_op("wide_neg1sq", 2'b00, ~108'd0, ~108'd0, 1'b1, 1'b1, 4, 180'd1, 16'd0);

        simd_r0 = 90'h123; simd_r1 = 90'h456; simd_c = 16'hA5;
        do_op("simd01", 2'b01, 108'd77, 108'd99, 1'b1, 1'b0, 1, {90'h456, 90'h123}, 16'hA5);
        simd_r0 = 90'h3FF; simd_r1 = 90'h1; simd_c = 16'h0F0F;
        do_op("simd11", 2'b11, 108'd5, 108'd6, 1'b0, 1'b1, 1, {90'h1, 90'h3FF}, 16'h0F0F);

        // Backpressure: hold result while a competing request is presented
        @(negedge clk);
        in_valid = 1'b1; op_mode = 2'b00; a = 108'd11; b = 108'd13; a_sign = 1'b0; b_sign = 1'b0;
        @(posedge clk); #1;
        a = 108'd1000; b = 108'd1000;
        n = 0;
        while (!out_valid0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", 180'(n), 180'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_product", product0, 180'd143);
            check("bp_in_ready", 180'(in_ready0), 180'd0);
            check("bp_out_valid", 180'(out_valid0), 180'd1);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_drop", 180'(out_valid0), 180'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_second", product0, 180'd143);
        check("bp_idle_ready", 180'(in_ready0), 180'd1);

        // MUL_LATENCY=2 instance: 12 cycles for a wide op
        @(negedge clk);
        in_valid2 = 1'b1; op_mode = 2'b00; a = 108'd3; b = 108'd5;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat2_latency", 180'(n), 180'd12);
        check("lat2_product", product2, 180'd15);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("lat2_drop", 180'(out_valid2), 180'd0);

        // Reset during pass p2 aborts the operation
        @(negedge clk);
        in_valid = 1'b1; op_mode = 2'b00; a = 108'd123; b = 108'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_in_p2", 180'(mas0 | mbs0 | out_valid0), 180'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 180'(out_valid0), 180'd0);
        check("abort_product", product0, 180'd0);
        check("abort_mul_a", 180'(ma0), 180'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", 180'(in_ready0), 180'd1);
        check("abort_out_valid2", 180'(out_valid0), 180'd0);
        do_op("after_abort", 2'b00, 108'd7, 108'd9, 1'b0, 1'b0, 4, 180'd63, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
